// File: rtl/ble_timing_loop_ctrl_if.sv
// ble_timing_loop_ctrl_if
// Bundles the receive-side controls, the bit stream and the timing-recovery
// drive signals of ble_timing_loop_ctrl.
//   master : packet-layer / stimulus side (drives enable, strobes, AA, length)
//   slave  : the controller itself (drives loop controls and bit stream out)
interface ble_timing_loop_ctrl_if;
  logic        enable;        // level: receive while high
  logic        update_data;   // one strobe per recovered bit
  logic        data_bit;      // valid with update_data
  logic [31:0] access_addr;   // expected AA, bit0 first over the air
  logic [11:0] payload_bits;  // payload length, sampled on sync
  logic        loop_rst_n;    // active-low reset to timing recovery / MF
  logic [2:0]  sample_point;
  logic [3:0]  e_k_shift;
  logic [4:0]  tau_shift;
  logic        sync;          // pulse on AA match
  logic        timeout;       // pulse on acquisition timeout
  logic        bit_valid;     // pulse per forwarded payload bit
  logic        bit_out;
  logic        done;          // pulse with the last payload bit
  logic [1:0]  state;         // 0 IDLE, 1 ACQ, 2 RELOCK, 3 TRACK

  modport master (
    output enable, update_data, data_bit, access_addr, payload_bits,
    input  loop_rst_n, sample_point, e_k_shift, tau_shift,
           sync, timeout, bit_valid, bit_out, done, state
  );

  modport slave (
    input  enable, update_data, data_bit, access_addr, payload_bits,
    output loop_rst_n, sample_point, e_k_shift, tau_shift,
           sync, timeout, bit_valid, bit_out, done, state
  );
endinterface

// File: rtl/ble_timing_loop_ctrl.sv
// ble_timing_loop_ctrl
// Sequencer for the BLE timing-recovery loop. Holds the loop in reset while
// idle, runs fast acquisition gains while correlating the access address
// (Hamming-tolerant, 32 bits), switches to slow tracking gains after sync and
// forwards a fixed number of payload bits before re-arming acquisition.
// Ports:
//   clk  : 16 MHz clock
//   rst  : asynchronous, active-low reset
//   bus  : ble_timing_loop_ctrl_if.slave
//          in  enable, update_data, data_bit, access_addr, payload_bits
//          out loop_rst_n, sample_point, e_k_shift, tau_shift,
//              sync, timeout, bit_valid, bit_out, done, state
// Every output is a flop.
module ble_timing_loop_ctrl #(
  parameter int ACQ_EK_SHIFT  = 2,
  parameter int ACQ_TAU_SHIFT = 10,
  parameter int TRK_EK_SHIFT  = 4,
  parameter int TRK_TAU_SHIFT = 11,
  parameter int SAMPLE_POINT  = 2,
  parameter int AA_MAX_ERR    = 1,
  parameter int ACQ_TIMEOUT   = 1024
) (
  input logic                   clk,
  input logic                   rst,
  ble_timing_loop_ctrl_if.slave bus
);

  localparam int              SCW     = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [SCW-1:0]  TMO     = SCW'(ACQ_TIMEOUT);
  localparam logic [5:0]      MAX_ERR = 6'(AA_MAX_ERR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    RELOCK = 2'd2,
    TRACK  = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [31:0]     sreg_q, sreg_n;
  logic [SCW-1:0]  scnt_q, scnt_n;
  logic [11:0]     bcnt_q, bcnt_n, bcnt_inc;
  logic [11:0]     len_q, len_n;
  logic            rc_q, rc_n;

  logic            loop_rst_n_q, loop_rst_n_n;
  logic [2:0]      sp_q;
  logic [3:0]      ek_q;
  logic [4:0]      tau_q;
  logic            sync_q, sync_n;
  logic            tmo_q, tmo_n;
  logic            bv_q, bv_n;
  logic            bo_q, bo_n;
  logic            done_q, done_n;

  // Popcount of the AA mismatch vector as a balanced adder tree.
  logic [31:0]      diff;
  logic [15:0][1:0] pc1;
  logic [7:0][2:0]  pc2;
  logic [3:0][3:0]  pc3;
  logic [1:0][4:0]  pc4;
  logic [5:0]       popcnt;
  logic             match;

  assign diff = sreg_q ^ bus.access_addr;

  always_comb begin
    for (int i = 0; i < 16; i++) pc1[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
    for (int i = 0; i < 8; i++)  pc2[i] = {1'b0, pc1[2*i]} + {1'b0, pc1[2*i+1]};
    for (int i = 0; i < 4; i++)  pc3[i] = {1'b0, pc2[2*i]} + {1'b0, pc2[2*i+1]};
    for (int i = 0; i < 2; i++)  pc4[i] = {1'b0, pc3[2*i]} + {1'b0, pc3[2*i+1]};
    popcnt = {1'b0, pc4[0]} + {1'b0, pc4[1]};
  end

  // Until 32 strobes have arrived the register still holds cleared bits, so a
  // sparse AA could otherwise match on the zero fill.
  assign match = (32'(scnt_q) >= 32'd32) && (popcnt <= MAX_ERR);

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    sreg_n    = sreg_q;
    scnt_n    = scnt_q;
    bcnt_n    = bcnt_q;
    len_n     = len_q;
    rc_n      = rc_q;
    sync_n    = 1'b0;
    tmo_n     = 1'b0;
    bv_n      = 1'b0;
    bo_n      = bo_q;
    done_n    = 1'b0;
    bcnt_inc  = bcnt_q + 12'd1;

    if (!bus.enable) begin
      // Dropping enable wins over everything, including a same-cycle strobe.
      state_n = IDLE;
      sreg_n  = '0;
      scnt_n  = '0;
      bcnt_n  = '0;
      rc_n    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = ACQ;
          sreg_n  = '0;
          scnt_n  = '0;
          bcnt_n  = '0;
          rc_n    = 1'b0;
        end
        ACQ: begin
          if (match) begin
            // Match beats a coincident timeout.
            sync_n  = 1'b1;
            state_n = TRACK;
            len_n   = bus.payload_bits;
            bcnt_n  = '0;
          end else if (scnt_q == TMO) begin
            tmo_n   = 1'b1;
            state_n = RELOCK;
            sreg_n  = '0;
            scnt_n  = '0;
            rc_n    = 1'b0;
          end else if (bus.update_data) begin
            sreg_n = {bus.data_bit, sreg_q[31:1]};
            scnt_n = scnt_q + SCW'(1);
          end
        end
        RELOCK: begin
          // Two cycles with the loop held in reset; strobes are ignored.
          sreg_n = '0;
          scnt_n = '0;
          bcnt_n = '0;
          rc_n   = 1'b1;
          if (rc_q) begin
            state_n = ACQ;
            rc_n    = 1'b0;
          end
        end
        TRACK: begin
          if (len_q == 12'd0) begin
            done_n  = 1'b1;
            state_n = ACQ;
            sreg_n  = '0;
            scnt_n  = '0;
            bcnt_n  = '0;
          end else if (bus.update_data) begin
            bv_n   = 1'b1;
            bo_n   = bus.data_bit;
            bcnt_n = bcnt_inc;
            if (bcnt_inc == len_q) begin
              done_n  = 1'b1;
              state_n = ACQ;
              sreg_n  = '0;
              scnt_n  = '0;
              bcnt_n  = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    loop_rst_n_n = (state_n == ACQ) || (state_n == TRACK);
  end

  // State and datapath registers. Gains follow the registered state, so a
  // gain change lands one cycle after the state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      len_q        <= '0;
      rc_q         <= 1'b0;
      loop_rst_n_q <= 1'b0;
      sp_q         <= 3'(SAMPLE_POINT);
      ek_q         <= 4'(ACQ_EK_SHIFT);
      tau_q        <= 5'(ACQ_TAU_SHIFT);
      sync_q       <= 1'b0;
      tmo_q        <= 1'b0;
      bv_q         <= 1'b0;
      bo_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      sreg_q       <= sreg_n;
      scnt_q       <= scnt_n;
      bcnt_q       <= bcnt_n;
      len_q        <= len_n;
      rc_q         <= rc_n;
      loop_rst_n_q <= loop_rst_n_n;
      sp_q         <= 3'(SAMPLE_POINT);
      ek_q         <= (state_q == TRACK) ? 4'(TRK_EK_SHIFT)  : 4'(ACQ_EK_SHIFT);
      tau_q        <= (state_q == TRACK) ? 5'(TRK_TAU_SHIFT) : 5'(ACQ_TAU_SHIFT);
      sync_q       <= sync_n;
      tmo_q        <= tmo_n;
      bv_q         <= bv_n;
      bo_q         <= bo_n;
      done_q       <= done_n;
    end
  end

  assign bus.state        = state_q;
  assign bus.loop_rst_n   = loop_rst_n_q;
  assign bus.sample_point = sp_q;
  assign bus.e_k_shift    = ek_q;
  assign bus.tau_shift    = tau_q;
  assign bus.sync         = sync_q;
  assign bus.timeout      = tmo_q;
  assign bus.bit_valid    = bv_q;
  assign bus.bit_out      = bo_q;
  assign bus.done         = done_q;

endmodule
